// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin selector arbiter.
//   NUM_REQ       : number of requesters sharing the selector
//   SEL_W         : width of the selector index
//   state_t       : arbiter FSM state
//   idx_to_onehot : index -> one-hot grant vector
package mux4_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between requester logic and the arbiter.
//   req     : per-requester request level
//   gnt     : one-hot grant, zero when idle
//   sel     : selector index of the current or last owner
//   busy    : a grant is active
//   timeout : one-cycle pulse after a tenure ended by hold expiry
// master = requester side, slave = arbiter side.
interface mux4_rr_arbiter_if;
    import mux4_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic               timeout;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy,
        output timeout
    );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker.
//   req : request vector
//   ptr : highest-priority index for this pick
//   any : at least one request is set
//   win : first requesting index found searching ptr, ptr+1, ... mod 4
module rr_pick4
    import mux4_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   win
);

    // Walk the four offsets from ptr; the index adder wraps naturally at SEL_W bits.
    always_comb begin
        logic [SEL_W-1:0] idx;
        any = 1'b0;
        win = '0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!any && req[idx]) begin
                any = 1'b1;
                win = idx;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the sel input of a shared 4:1 selector.
// Grants one requester at a time for at most MAX_HOLD cycles, with a
// one-cycle idle bubble between tenures. All outputs are registered.
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of mux4_rr_arbiter_if (req in; gnt/sel/busy/timeout out)
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mux4_rr_arbiter_if.slave     bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

    state_t             state_q, state_n;
    logic [NUM_REQ-1:0] gnt_q,   gnt_n;
    logic [SEL_W-1:0]   sel_q,   sel_n;
    logic               busy_q,  busy_n;
    logic               tout_q,  tout_n;
    logic [SEL_W-1:0]   ptr_q,   ptr_n;
    logic [CNT_W-1:0]   cnt_q,   cnt_n;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_win;

    // Arbitration is only consumed in IDLE.
    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .any (pick_any),
        .win (pick_win)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            busy_q  <= busy_n;
            tout_q  <= tout_n;
            ptr_q   <= ptr_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next-state and next-output logic. sel_q doubles as the owner index in GRANT.
    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        busy_n  = busy_q;
        tout_n  = 1'b0;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    gnt_n   = idx_to_onehot(pick_win);
                    sel_n   = pick_win;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                // A drop on the expiry cycle is voluntary, so check req first.
                if (!bus.req[sel_q] || (cnt_q == LAST_CNT)) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    busy_n  = 1'b0;
                    tout_n  = bus.req[sel_q];
                    ptr_n   = sel_q + SEL_W'(1);
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = tout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter (MAX_HOLD = 8).
module tb_mux4_rr_arbiter;

    localparam int unsigned MH = 8;

    logic clk;
    logic rst;

    mux4_rr_arbiter_if bus ();

    mux4_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner index (-1 = idle), cycles granted so far,
    // rotating priority start, last selector value, timeout flag.
    int m_owner = -1;
    int m_held  = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    bit m_to    = 1'b0;

    task automatic model_edge(input logic r, input logic [3:0] q);
        bit found;
        m_to = 1'b0;
        if (r) begin
            m_owner = -1;
            m_held  = 0;
            m_ptr   = 0;
            m_sel   = 0;
        end else if (m_owner < 0) begin
            found = 1'b0;
            for (int off = 0; off < 4; off++) begin
                int c;
                c = (m_ptr + off) % 4;
                if (!found && q[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_sel   = c;
                    m_held  = 1;
                end
            end
        end else if (!q[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else if (m_held == int'(MH)) begin
            m_to    = 1'b1;
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end else begin
            m_held = m_held + 1;
        end
    endtask

    // Apply inputs, clock once, advance the model, settle past the edge.
    task automatic tick(input logic r, input logic [3:0] q);
        rst     = r;
        bus.req = q;
        @(posedge clk);
        model_edge(r, q);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [1:0] es,
                         input logic eb, input logic et);
        n_cmp++;
        if (bus.gnt !== eg || bus.sel !== es || bus.busy !== eb || bus.timeout !== et) begin
            n_bad++;
            $display("FAIL %s @%0t: got gnt=%b sel=%b busy=%b timeout=%b, expected gnt=%b sel=%b busy=%b timeout=%b",
                     name, $time, bus.gnt, bus.sel, bus.busy, bus.timeout, eg, es, eb, et);
        end
    endtask

    typedef struct {
        logic       r;
        logic [3:0] q;
        logic [3:0] eg;
        logic [1:0] es;
        logic       eb;
        logic       et;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [3:0] eg;
        int t;
        int p;

        rst     = 1'b1;
        bus.req = 4'b0000;

        // Reset, first grant, single requester, wrap from ptr=3.
        vecs[0]  = '{1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 4'b1111, 4'b0000, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 4'b1111, 4'b0001, 2'b00, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 2'b10, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 4'b0101, 4'b0001, 2'b00, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'b0100, 4'b0000, 2'b00, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 4'b0101, 4'b0100, 2'b10, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'b0000, 4'b0000, 2'b10, 1'b0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            tick(vecs[i].r, vecs[i].q);
            check($sformatf("vec%0d", i), vecs[i].eg, vecs[i].es, vecs[i].eb, vecs[i].et);
        end

        // Rotation with all requesting: 8-cycle tenures, timeout in each bubble.
        tick(1'b1, 4'b0000);
        check("rot_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 45; k++) begin
            tick(1'b0, 4'b1111);
            t  = k / 9;
            p  = k % 9;
            eg = (p < 8) ? 4'(1 << (t % 4)) : 4'b0000;
            check($sformatf("rot%0d", k), eg, 2'(t % 4), p < 8, p == 8);
        end

        // Owner drops exactly on its final permitted cycle: voluntary release.
        tick(1'b1, 4'b0000);
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 4'b0010);
            check($sformatf("edge_hold%0d", k), 4'b0010, 2'b01, 1'b1, 1'b0);
        end
        tick(1'b0, 4'b0000);
        check("edge_release", 4'b0000, 2'b01, 1'b0, 1'b0);
        tick(1'b0, 4'b0000);
        check("edge_after", 4'b0000, 2'b01, 1'b0, 1'b0);

        // Reset in the 4th cycle of a tenure drops it silently.
        tick(1'b1, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 4'b0010);
            check($sformatf("mid_hold%0d", k), 4'b0010, 2'b01, 1'b1, 1'b0);
        end
        tick(1'b1, 4'b0010);
        check("mid_reset", 4'b0000, 2'b00, 1'b0, 1'b0);
        tick(1'b0, 4'b1111);
        check("mid_regrant", 4'b0001, 2'b00, 1'b1, 1'b0);

        // Randomized traffic against the reference model.
        begin
            logic [3:0] q;
            logic       r;
            q = 4'b0000;
            for (int k = 0; k < 3000; k++) begin
                if ($urandom_range(0, 3) == 0) q = 4'($urandom_range(0, 15));
                r = ($urandom_range(0, 63) == 0);
                tick(r, q);
                eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
                check("rand", eg, 2'(m_sel), m_owner >= 0, m_to);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
